// File: rtl/write_response_channel_pkg.sv
// Shared types and constants for the AXI write-response (B) router.
// Optional build macro used by the router: AXI_B_TIMEOUT_EN.
package write_response_channel_pkg;

    typedef enum logic [1:0] {
        B_IDLE    = 2'd0,
        B_WAIT_S0 = 2'd1,
        B_WAIT_S1 = 2'd2,
        B_RESP    = 2'd3
    } b_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SEL_S0  = 2'd0;
    localparam logic [1:0] SEL_S1  = 2'd1;
    localparam logic [1:0] SEL_DEF = 2'd2;

    localparam logic [3:0] M1_TAG = 4'b0001;

    // The reserved select code routes to the default (DECERR) slave.
    function automatic logic [1:0] norm_sel(input logic [1:0] sel);
        return (sel == 2'd3) ? SEL_DEF : sel;
    endfunction

endpackage

// File: rtl/write_response_channel_if.sv
// One AXI B channel (ID, response, valid/ready); master drives the response.
interface write_response_channel_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    modport master (output BID, output BRESP, output BVALID, input BREADY);
    modport slave  (input BID, input BRESP, input BVALID, output BREADY);
endinterface

// File: rtl/write_response_channel_b_resp_reg.sv
// Response holding register: load captures ID/RESP and raises valid, clr empties it.
// Outputs stay stable between load and clr, so it also suits the R-channel router.
module b_resp_reg #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clr,
    input  logic [ID_W-1:0] id_in,
    input  logic [1:0]      resp_in,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o,
    output logic [1:0]      resp_o
);
    logic            valid_q, valid_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [1:0]      resp_q, resp_d;

    // Next-state of the holding register.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        resp_d  = resp_q;
        if (clr) begin
            valid_d = 1'b0;
            id_d    = '0;
            resp_d  = 2'b00;
        end else if (load) begin
            valid_d = 1'b1;
            id_d    = id_in;
            resp_d  = resp_in;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            resp_q  <= 2'b00;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            resp_q  <= resp_d;
        end
    end

    assign valid_o = valid_q;
    assign id_o    = id_q;
    assign resp_o  = resp_q;

endmodule

// File: rtl/write_response_channel.sv
// B-channel router: waits on the selected slave, strips the master tag, presents to M1.
// Build macro AXI_B_TIMEOUT_EN adds a slave-response timeout that returns SLVERR.
module write_response_channel
    import write_response_channel_pkg::*;
#(
    parameter int                        M_ID_W  = 4,
    parameter int                        S_ID_W  = 8,
    parameter logic [S_ID_W-M_ID_W-1:0]  M1_TAG  = write_response_channel_pkg::M1_TAG,
    parameter int                        TIMEOUT = 256
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           route_valid,
    input  logic [1:0]                     route_sel,
    output logic                           route_ready,
    write_response_channel_if.slave        b_s0,
    write_response_channel_if.slave        b_s1,
    write_response_channel_if.master       b_m1,
    output logic                           b_done,
    output logic                           id_err
);
    localparam int TAG_W = S_ID_W - M_ID_W;

    b_state_e          state_q, state_d;
    logic              b_done_q, b_done_d;
    logic              id_err_q, id_err_d;
    logic              load_s, clr_s;
    logic [M_ID_W-1:0] load_id_s;
    logic [1:0]        load_resp_s;
    logic              s_valid_s;
    logic [S_ID_W-1:0] s_id_s;
    logic [1:0]        s_resp_s;

`ifdef AXI_B_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT) < 8) ? 8 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_s;
`endif

    // Slave-side mux: only the slave being waited on is visible.
    always_comb begin
        s_valid_s = 1'b0;
        s_id_s    = b_s0.BID;
        s_resp_s  = b_s0.BRESP;
        case (state_q)
            B_WAIT_S0: s_valid_s = b_s0.BVALID;
            B_WAIT_S1: begin
                s_valid_s = b_s1.BVALID;
                s_id_s    = b_s1.BID;
                s_resp_s  = b_s1.BRESP;
            end
            default: s_valid_s = 1'b0;
        endcase
    end

`ifdef AXI_B_TIMEOUT_EN
    // Counter is held at zero in IDLE, so it starts clean on every WAIT entry.
    always_comb begin
        cnt_d    = cnt_q;
        expire_s = 1'b0;
        if (state_q == B_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == B_WAIT_S0 || state_q == B_WAIT_S1) && !s_valid_s) begin
            cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            expire_s = (cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin
            cnt_d = cnt_q;
        end
    end
`endif

    // Router next-state and register-load decisions.
    always_comb begin
        state_d     = state_q;
        load_s      = 1'b0;
        clr_s       = 1'b0;
        load_id_s   = '0;
        load_resp_s = RESP_OKAY;
        b_done_d    = 1'b0;
        id_err_d    = 1'b0;
        case (state_q)
            B_IDLE: begin
                if (route_valid) begin
                    case (norm_sel(route_sel))
                        SEL_S0:  state_d = B_WAIT_S0;
                        SEL_S1:  state_d = B_WAIT_S1;
                        default: begin
                            state_d     = B_RESP;
                            load_s      = 1'b1;
                            load_resp_s = RESP_DECERR;
                        end
                    endcase
                end else begin
                    state_d = B_IDLE;
                end
            end
            B_WAIT_S0, B_WAIT_S1: begin
                if (s_valid_s) begin
                    state_d     = B_RESP;
                    load_s      = 1'b1;
                    load_id_s   = s_id_s[M_ID_W-1:0];
                    load_resp_s = s_resp_s;
                    id_err_d    = (s_id_s[S_ID_W-1:M_ID_W] != M1_TAG);
`ifdef AXI_B_TIMEOUT_EN
                end else if (expire_s) begin
                    state_d     = B_RESP;
                    load_s      = 1'b1;
                    load_resp_s = RESP_SLVERR;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            B_RESP: begin
                if (b_m1.BREADY) begin
                    state_d  = B_IDLE;
                    clr_s    = 1'b1;
                    b_done_d = 1'b1;
                end else begin
                    state_d = B_RESP;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    // Router state and pulse flops.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= B_IDLE;
            b_done_q <= 1'b0;
            id_err_q <= 1'b0;
`ifdef AXI_B_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            b_done_q <= b_done_d;
            id_err_q <= id_err_d;
`ifdef AXI_B_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    b_resp_reg #(
        .ID_W (M_ID_W)
    ) u_b_resp_reg (
        .clk     (ACLK),
        .rst     (ARESET),
        .load    (load_s),
        .clr     (clr_s),
        .id_in   (load_id_s),
        .resp_in (load_resp_s),
        .valid_o (b_m1.BVALID),
        .id_o    (b_m1.BID),
        .resp_o  (b_m1.BRESP)
    );

    assign route_ready = (state_q == B_IDLE);
    assign b_s0.BREADY = (state_q == B_WAIT_S0);
    assign b_s1.BREADY = (state_q == B_WAIT_S1);
    assign b_done      = b_done_q;
    assign id_err      = id_err_q;

endmodule

// File: tb/tb_write_response_channel.sv
// Randomized transaction-level bench for write_response_channel with a reference model.
// Exercises the AXI_B_TIMEOUT_EN path only when that macro is defined.
module tb_write_response_channel;

    localparam int         TIMEOUT = 256;
    localparam logic [3:0] TAG     = 4'b0001;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       route_valid = 1'b0;
    logic [1:0] route_sel = 2'd0;
    logic       route_ready;
    logic       b_done;
    logic       id_err;

    int n_cmp = 0;
    int n_err = 0;

    write_response_channel_if #(.ID_W(8)) s0_if ();
    write_response_channel_if #(.ID_W(8)) s1_if ();
    write_response_channel_if #(.ID_W(4)) m1_if ();

    write_response_channel #(
        .M_ID_W  (4),
        .S_ID_W  (8),
        .M1_TAG  (TAG),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .route_valid (route_valid),
        .route_sel   (route_sel),
        .route_ready (route_ready),
        .b_s0        (s0_if),
        .b_s1        (s1_if),
        .b_m1        (m1_if),
        .b_done      (b_done),
        .id_err      (id_err)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what M1 should see, as {id[3:0], resp[1:0]}.
    function automatic logic [5:0] exp_rsp(input int sel, input logic [7:0] bid, input logic [1:0] bresp);
        if (sel >= 2) return {4'h0, 2'b11};
        return {bid[3:0], bresp};
    endfunction

    // Random chatter on every slave except the one being waited on.
    task automatic noise_slaves(input int sel);
        if (sel != 0) begin
            s0_if.BVALID = 1'($urandom % 2);
            s0_if.BID    = 8'($urandom);
            s0_if.BRESP  = 2'($urandom);
        end
        if (sel != 1) begin
            s1_if.BVALID = 1'($urandom % 2);
            s1_if.BID    = 8'($urandom);
            s1_if.BRESP  = 2'($urandom);
        end
    endtask

    task automatic quiet_slaves();
        s0_if.BVALID = 1'b0;
        s1_if.BVALID = 1'b0;
    endtask

    // One full transaction; entered and left at a negedge with the DUT in IDLE.
    task automatic do_txn(input int sel, input int delay, input logic [7:0] bid,
                          input logic [1:0] bresp, input int bp);
        logic [5:0] e;
        logic       e_ierr;
        e      = exp_rsp(sel, bid, bresp);
        e_ierr = (sel < 2) && (bid[7:4] != TAG);

        check_eq("route_ready_idle", 32'(route_ready), 32'd1);
        route_valid   = 1'b1;
        route_sel     = 2'(sel);
        m1_if.BREADY  = 1'b0;
        noise_slaves(sel);
        @(negedge ACLK);
        route_valid = 1'b0;

        if (sel < 2) begin
            for (int d = 0; d <= delay; d++) begin
                check_eq("bready_sel", 32'((sel == 0) ? s0_if.BREADY : s1_if.BREADY), 32'd1);
                check_eq("bready_other", 32'((sel == 0) ? s1_if.BREADY : s0_if.BREADY), 32'd0);
                check_eq("bvalid_m1_wait", 32'(m1_if.BVALID), 32'd0);
                check_eq("route_ready_wait", 32'(route_ready), 32'd0);
                check_eq("b_done_wait", 32'(b_done), 32'd0);
                check_eq("id_err_wait", 32'(id_err), 32'd0);
                route_valid = 1'($urandom % 2);
                route_sel   = 2'($urandom);
                noise_slaves(sel);
                if (sel == 0) begin
                    s0_if.BVALID = (d == delay);
                    s0_if.BID    = (d == delay) ? bid : 8'($urandom);
                    s0_if.BRESP  = (d == delay) ? bresp : 2'($urandom);
                end else begin
                    s1_if.BVALID = (d == delay);
                    s1_if.BID    = (d == delay) ? bid : 8'($urandom);
                    s1_if.BRESP  = (d == delay) ? bresp : 2'($urandom);
                end
                @(negedge ACLK);
            end
            quiet_slaves();
        end

        for (int c = 0; c <= bp; c++) begin
            check_eq("bvalid_m1", 32'(m1_if.BVALID), 32'd1);
            check_eq("bid_m1", 32'(m1_if.BID), 32'(e[5:2]));
            check_eq("bresp_m1", 32'(m1_if.BRESP), 32'(e[1:0]));
            check_eq("id_err", 32'(id_err), 32'((c == 0) ? e_ierr : 1'b0));
            check_eq("b_done_resp", 32'(b_done), 32'd0);
            check_eq("route_ready_resp", 32'(route_ready), 32'd0);
            check_eq("bready_s0_resp", 32'(s0_if.BREADY), 32'd0);
            check_eq("bready_s1_resp", 32'(s1_if.BREADY), 32'd0);
            route_valid  = 1'($urandom % 2);
            route_sel    = 2'($urandom);
            noise_slaves(2);
            m1_if.BREADY = (c == bp);
            @(negedge ACLK);
        end
        route_valid  = 1'b0;
        m1_if.BREADY = 1'b0;
        quiet_slaves();
        check_eq("b_done_pulse", 32'(b_done), 32'd1);
        check_eq("route_ready_after", 32'(route_ready), 32'd1);
        check_eq("bvalid_m1_after", 32'(m1_if.BVALID), 32'd0);
    endtask

    initial begin
        int         sel;
        logic [7:0] bid;
        s0_if.BVALID = 1'b0; s0_if.BID = 8'h00; s0_if.BRESP = 2'b00;
        s1_if.BVALID = 1'b0; s1_if.BID = 8'h00; s1_if.BRESP = 2'b00;
        m1_if.BREADY = 1'b0;

        repeat (3) @(negedge ACLK);
        check_eq("rst_bvalid_m1", 32'(m1_if.BVALID), 32'd0);
        check_eq("rst_bid_m1", 32'(m1_if.BID), 32'd0);
        check_eq("rst_bresp_m1", 32'(m1_if.BRESP), 32'd0);
        check_eq("rst_bready_s0", 32'(s0_if.BREADY), 32'd0);
        check_eq("rst_bready_s1", 32'(s1_if.BREADY), 32'd0);
        check_eq("rst_b_done", 32'(b_done), 32'd0);
        check_eq("rst_id_err", 32'(id_err), 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);

        do_txn(0, 2, 8'h13, 2'b00, 0);
        do_txn(1, 1, 8'h15, 2'b10, 0);
        do_txn(2, 0, 8'h00, 2'b00, 0);
        do_txn(0, 0, 8'h1A, 2'b01, 5);
        do_txn(1, 0, 8'h25, 2'b00, 1);
        do_txn(3, 0, 8'h00, 2'b00, 2);
        do_txn(0, 0, 8'h1F, 2'b11, 0);

        // Reset while waiting on S0 abandons the transaction silently.
        route_valid = 1'b1;
        route_sel   = 2'd0;
        @(negedge ACLK);
        route_valid = 1'b0;
        check_eq("mid_bready_s0", 32'(s0_if.BREADY), 32'd1);
        ARESET       = 1'b1;
        s0_if.BVALID = 1'b1;
        s0_if.BID    = 8'h17;
        s0_if.BRESP  = 2'b01;
        @(negedge ACLK);
        ARESET = 1'b0;
        quiet_slaves();
        check_eq("mrst_bvalid_m1", 32'(m1_if.BVALID), 32'd0);
        check_eq("mrst_bid_m1", 32'(m1_if.BID), 32'd0);
        check_eq("mrst_bresp_m1", 32'(m1_if.BRESP), 32'd0);
        check_eq("mrst_bready_s0", 32'(s0_if.BREADY), 32'd0);
        check_eq("mrst_b_done", 32'(b_done), 32'd0);
        check_eq("mrst_route_ready", 32'(route_ready), 32'd1);
        @(negedge ACLK);
        check_eq("mrst_b_done_next", 32'(b_done), 32'd0);
        check_eq("mrst_bvalid_next", 32'(m1_if.BVALID), 32'd0);

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 3));
            bid = 8'($urandom);
            if (($urandom % 4) != 0) bid[7:4] = TAG;
            do_txn(sel, int'($urandom_range(0, 6)), bid, 2'($urandom), int'($urandom_range(0, 4)));
        end

`ifdef AXI_B_TIMEOUT_EN
        begin
            int n;
            route_valid = 1'b1;
            route_sel   = 2'd1;
            @(negedge ACLK);
            route_valid = 1'b0;
            n = 0;
            while (!m1_if.BVALID && n < TIMEOUT + 8) begin
                @(negedge ACLK);
                n++;
            end
            check_eq("to_reached", 32'(m1_if.BVALID), 32'd1);
            check_eq("to_cycles", 32'(n), 32'(TIMEOUT));
            check_eq("to_bresp", 32'(m1_if.BRESP), 32'd2);
            check_eq("to_bid", 32'(m1_if.BID), 32'd0);
            check_eq("to_bready_s1", 32'(s1_if.BREADY), 32'd0);
            check_eq("to_id_err", 32'(id_err), 32'd0);
            s1_if.BVALID = 1'b1;
            s1_if.BID    = 8'h1C;
            s1_if.BRESP  = 2'b00;
            m1_if.BREADY = 1'b1;
            @(negedge ACLK);
            m1_if.BREADY = 1'b0;
            quiet_slaves();
            check_eq("to_b_done", 32'(b_done), 32'd1);
            check_eq("to_idle", 32'(route_ready), 32'd1);
            check_eq("to_late_ignored", 32'(m1_if.BVALID), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/write_response_channel.md
Name: write_response_channel

Overview:
- B-channel (write response) router between slaves S0/S1 and master M1 in the AXI interconnect; the counterpart of the write address channel.
- Accepts a route command from the write FSM after the last W beat and waits for BVALID from the selected slave.
- Registers the response, strips the 4-bit master tag from the slave ID, and presents it to M1.
- Generates DECERR locally for the default (unmapped) slave, and pulses b_done so the write FSM can return to IDLE.

Parameters:
- M_ID_W, `AXI_ID_BITS (4), master-side ID width.
- S_ID_W, `AXI_IDS_BITS (8), slave-side ID width; upper S_ID_W-M_ID_W bits carry the master tag.
- M1_TAG, 4'b0001, expected master tag in BID_Sx upper bits.
- TIMEOUT, 256, cycles to wait for slave BVALID (used only with the optional feature).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- route_valid  in  1  write FSM requests response routing.
- route_sel  in  2  0=S0, 1=S1, 2=default slave (DECERR), 3=reserved (treated as 2).
- route_ready  out  1  high only in IDLE.
- BID_S0  in  S_ID_W  slave 0 response ID.
- BRESP_S0  in  2  slave 0 response.
- BVALID_S0  in  1  slave 0 response valid.
- BREADY_S0  out  1  ready to slave 0.
- BID_S1  in  S_ID_W  slave 1 response ID.
- BRESP_S1  in  2  slave 1 response.
- BVALID_S1  in  1  slave 1 response valid.
- BREADY_S1  out  1  ready to slave 1.
- BID_M1  out  M_ID_W  response ID to M1.
- BRESP_M1  out  2  response to M1.
- BVALID_M1  out  1  response valid to M1.
- BREADY_M1  in  1  M1 ready.
- b_done  out  1  one-cycle pulse when the M1 B handshake completes.
- id_err  out  1  one-cycle pulse when a captured slave ID tag != M1_TAG.

Behaviour:
- Reset (synchronous, ARESET=1 at posedge): state=IDLE; BID_M1=0, BRESP_M1=0, BVALID_M1=0, BREADY_S0/S1=0, b_done=0, id_err=0; capture register cleared. Reset mid-transaction abandons it; no b_done is issued.
- States: IDLE, WAIT_S0, WAIT_S1, RESP.
- IDLE:
  - route_ready=1.
  - route_valid with sel=0 -> WAIT_S0; sel=1 -> WAIT_S1.
  - route_valid with sel=2/3 -> RESP with BRESP=2'b11 and BID=0.
- WAIT_Sx:
  - BREADY_Sx=1 (combinational, from state); the other slave's BREADY=0, so its BVALID is ignored.
  - On BVALID_Sx: capture BID_Sx[M_ID_W-1:0] and BRESP_Sx, then -> RESP.
  - id_err pulses in the cycle after capture if BID_Sx[S_ID_W-1:M_ID_W] != M1_TAG; the response is still forwarded unchanged.
- RESP:
  - BVALID_M1=1, driven from a register.
  - BID_M1/BRESP_M1 hold stable until BREADY_M1=1; then -> IDLE and b_done=1 for the following cycle.
- Latency:
  - Slave handshake to BVALID_M1: 1 cycle.
  - M1 handshake to route_ready: 1 cycle.
  - Minimum 3 cycles per transaction, from route accept to IDLE again.
- route_valid outside IDLE is ignored (route_ready=0); the command is not queued.
- BVALID_Sx and BREADY_M1 are not combinationally coupled; there is no combinational path from slave to master.
- BRESP passes through unmodified (OKAY/EXOKAY/SLVERR/DECERR).

Optional Feature:
- Macro: AXI_B_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to WAIT_Sx and increments each cycle without BVALID_Sx.
  - When the counter reaches TIMEOUT-1: -> RESP with BRESP=2'b10 (SLVERR), BID=0, BREADY_Sx dropped.
  - A late slave BVALID is then ignored.
- Undefined: no counter exists; WAIT_Sx holds indefinitely.

Decomposition:
- Shared package axi_pkg:
  - typedef enum for B-router states.
  - localparams RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Route select codes SEL_S0/SEL_S1/SEL_DEF.
  - M1_TAG constant.
- Sub-module b_resp_reg:
  - Holding register: load, clear, stable ID/RESP/VALID outputs.
  - Reusable for the R-channel router.

Test Plan:
- Route sel=0; S0 BVALID with BID=8'h13, BRESP=00 two cycles later; BREADY_M1=1 -> BVALID_M1 one cycle after capture, BID_M1=4'h3, BRESP_M1=00, b_done pulse, route_ready=1 next cycle.
- Route sel=1; S0 asserts spurious BVALID, then S1 returns BID=8'h15, BRESP=10 -> BREADY_S0 stays 0; M1 receives BID=4'h5, BRESP=10.
- Route sel=2 -> BVALID_M1 next cycle with BRESP=11, BID=0; no slave BREADY asserted.
- Backpressure: BREADY_M1=0 for 5 cycles in RESP -> BID/BRESP/BVALID_M1 stable for all 5; route_valid during RESP ignored.
- S1 returns BID=8'h25 -> id_err pulses once; response still forwarded as BID_M1=4'h5.
- ARESET asserted while in WAIT_S0 -> all outputs 0 next cycle, state IDLE, no b_done. With AXI_B_TIMEOUT_EN and no BVALID for TIMEOUT cycles -> BRESP_M1=10.
